// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the hazard controller: FSM states,
// forward-select encodings and the default register-index width.
package pipeline_hazard_ctrl_pkg;

    localparam int REG_ADDR_WIDTH = 5;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Per-operand forwarding bundle: the hazard unit (master) supplies the source
// and the M/W destinations, forward_sel (slave) returns the operand select.
interface pipeline_hazard_ctrl_if #(
    parameter int AW = pipeline_hazard_ctrl_pkg::REG_ADDR_WIDTH
);
    logic [AW-1:0] rs;
    logic [AW-1:0] rd_m;
    logic [AW-1:0] rd_w;
    logic          reg_write_m;
    logic          reg_write_w;
    logic [1:0]    fwd;

    modport master (output rs, rd_m, rd_w, reg_write_m, reg_write_w, input fwd);
    modport slave  (input rs, rd_m, rd_w, reg_write_m, reg_write_w, output fwd);
endinterface

// File: rtl/pipeline_hazard_ctrl_forward_sel.sv
// Forwarding compare for one ALU operand; the younger M result wins over W,
// and x0 never forwards.
module forward_sel
    import pipeline_hazard_ctrl_pkg::*;
(
    pipeline_hazard_ctrl_if.slave fs
);
    logic hit_m;
    logic hit_w;

    assign hit_m  = fs.reg_write_m && (fs.rd_m != '0) && (fs.rd_m == fs.rs);
    assign hit_w  = fs.reg_write_w && (fs.rd_w != '0) && (fs.rd_w == fs.rs);
    assign fs.fwd = hit_m ? FWD_MEM : (hit_w ? FWD_WB : FWD_REG);
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use / branch / memory-wait stalls and flushes,
// operand forwarding (build with FORWARDING_EN; otherwise RAW hazards stall).
module pipeline_hazard_ctrl #(
    parameter int REG_ADDR_WIDTH = pipeline_hazard_ctrl_pkg::REG_ADDR_WIDTH,
    parameter int CNT_WIDTH      = 32,
    parameter int MEM_TIMEOUT    = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [REG_ADDR_WIDTH-1:0] rs1D_i,
    input  logic [REG_ADDR_WIDTH-1:0] rs2D_i,
    input  logic [REG_ADDR_WIDTH-1:0] rs1E_i,
    input  logic [REG_ADDR_WIDTH-1:0] rs2E_i,
    input  logic [REG_ADDR_WIDTH-1:0] rdE_i,
    input  logic [REG_ADDR_WIDTH-1:0] rdM_i,
    input  logic [REG_ADDR_WIDTH-1:0] rdW_i,
    input  logic                      regWriteE_i,
    input  logic                      regWriteM_i,
    input  logic                      regWriteW_i,
    input  logic                      resultSrcE_i,
    input  logic                      pcSrcE_i,
    input  logic                      memReqM_i,
    input  logic                      memAckM_i,
    output logic                      stallF_o,
    output logic                      stallD_o,
    output logic                      stallE_o,
    output logic                      stallM_o,
    output logic                      flushD_o,
    output logic                      flushE_o,
    output logic                      flushW_o,
    output logic [1:0]                forwardAE_o,
    output logic [1:0]                forwardBE_o,
    output logic [CNT_WIDTH-1:0]      stallCnt_o,
    output logic                      memErr_o
);
    import pipeline_hazard_ctrl_pkg::*;

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    state_t            state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic              mem_stall;
    logic              load_use;
    logic              raw_stall;
    logic              any_stall;

    always_ff @(posedge clk) begin
        if (rst) state <= RUN;
        else     state <= state_nxt;
    end

    // The cycle the ack arrives is not stalled: M completes and the pipe moves.
    always_comb begin
        state_nxt = state;
        mem_stall = 1'b0;
        case (state)
            RUN: begin
                if (memReqM_i && !memAckM_i) begin
                    state_nxt = MEM_WAIT;
                    mem_stall = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (memAckM_i) state_nxt = RUN;
                else           mem_stall = 1'b1;
            end
            default: state_nxt = RUN;
        endcase
    end

    assign load_use = resultSrcE_i && (rdE_i != '0) &&
                      ((rdE_i == rs1D_i) || (rdE_i == rs2D_i));

`ifdef FORWARDING_EN
    pipeline_hazard_ctrl_if #(.AW(REG_ADDR_WIDTH)) fa_if ();
    pipeline_hazard_ctrl_if #(.AW(REG_ADDR_WIDTH)) fb_if ();

    assign fa_if.rs          = rs1E_i;
    assign fa_if.rd_m        = rdM_i;
    assign fa_if.rd_w        = rdW_i;
    assign fa_if.reg_write_m = regWriteM_i;
    assign fa_if.reg_write_w = regWriteW_i;
    assign fb_if.rs          = rs2E_i;
    assign fb_if.rd_m        = rdM_i;
    assign fb_if.rd_w        = rdW_i;
    assign fb_if.reg_write_m = regWriteM_i;
    assign fb_if.reg_write_w = regWriteW_i;

    forward_sel u_fwd_a (.fs(fa_if));
    forward_sel u_fwd_b (.fs(fb_if));

    assign raw_stall   = load_use;
    assign forwardAE_o = rst ? FWD_REG : fa_if.fwd;
    assign forwardBE_o = rst ? FWD_REG : fb_if.fwd;

    logic unused_nofwd;
    assign unused_nofwd = regWriteE_i;
`else
    // No bypass network: any in-flight nonzero write to a decode source must wait.
    logic raw_e;
    logic raw_m;
    assign raw_e = regWriteE_i && (rdE_i != '0) && ((rdE_i == rs1D_i) || (rdE_i == rs2D_i));
    assign raw_m = regWriteM_i && (rdM_i != '0) && ((rdM_i == rs1D_i) || (rdM_i == rs2D_i));

    assign raw_stall   = load_use || raw_e || raw_m;
    assign forwardAE_o = FWD_REG;
    assign forwardBE_o = FWD_REG;

    logic unused_fwd;
    assign unused_fwd = ^{rs1E_i, rs2E_i, rdW_i, regWriteW_i};
`endif

    // A memory stall holds E, so a pending branch is simply seen again later.
    always_comb begin
        stallF_o = 1'b0;
        stallD_o = 1'b0;
        stallE_o = 1'b0;
        stallM_o = 1'b0;
        flushD_o = 1'b0;
        flushE_o = 1'b0;
        flushW_o = 1'b0;
        if (!rst) begin
            if (mem_stall) begin
                stallF_o = 1'b1;
                stallD_o = 1'b1;
                stallE_o = 1'b1;
                stallM_o = 1'b1;
                flushW_o = 1'b1;
            end else if (pcSrcE_i) begin
                flushD_o = 1'b1;
                flushE_o = 1'b1;
            end else if (raw_stall) begin
                stallF_o = 1'b1;
                stallD_o = 1'b1;
                flushE_o = 1'b1;
            end
        end
    end

    assign any_stall = stallF_o || stallD_o || stallE_o || stallM_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
            memErr_o <= 1'b0;
        end else begin
            if (state == MEM_WAIT && state_nxt == MEM_WAIT) begin
                if (wait_cnt != WAIT_W'(MEM_TIMEOUT)) wait_cnt <= wait_cnt + 1'b1;
            end else begin
                wait_cnt <= '0;
            end
            if (state == MEM_WAIT && wait_cnt == WAIT_W'(MEM_TIMEOUT - 1))
                memErr_o <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)                                  stallCnt_o <= '0;
        else if (any_stall && (stallCnt_o != '1)) stallCnt_o <= stallCnt_o + 1'b1;
    end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl (default or FORWARDING_EN build)
// plus a standalone check of forward_sel through the interface.
module tb_pipeline_hazard_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic       regWriteE, regWriteM, regWriteW, resultSrcE, pcSrcE, memReqM, memAckM;
    logic       stallF, stallD, stallE, stallM, flushD, flushE, flushW, memErr;
    logic [1:0] forwardAE, forwardBE;
    logic [31:0] stallCnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl dut (
        .clk(clk), .rst(rst),
        .rs1D_i(rs1D), .rs2D_i(rs2D), .rs1E_i(rs1E), .rs2E_i(rs2E),
        .rdE_i(rdE), .rdM_i(rdM), .rdW_i(rdW),
        .regWriteE_i(regWriteE), .regWriteM_i(regWriteM), .regWriteW_i(regWriteW),
        .resultSrcE_i(resultSrcE), .pcSrcE_i(pcSrcE),
        .memReqM_i(memReqM), .memAckM_i(memAckM),
        .stallF_o(stallF), .stallD_o(stallD), .stallE_o(stallE), .stallM_o(stallM),
        .flushD_o(flushD), .flushE_o(flushE), .flushW_o(flushW),
        .forwardAE_o(forwardAE), .forwardBE_o(forwardBE),
        .stallCnt_o(stallCnt), .memErr_o(memErr)
    );

    pipeline_hazard_ctrl_if tif ();
    forward_sel u_fs (.fs(tif));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        rs1D = 0; rs2D = 0; rs1E = 0; rs2E = 0; rdE = 0; rdM = 0; rdW = 0;
        regWriteE = 0; regWriteM = 0; regWriteW = 0;
        resultSrcE = 0; pcSrcE = 0; memReqM = 0; memAckM = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clear();
        rst = 1;
        // Reset held with every hazard source active: outputs stay quiet
        tick();
        memReqM = 1; pcSrcE = 1; resultSrcE = 1; rdE = 5; rs1D = 5;
        rdM = 3; regWriteM = 1; rs1E = 3;
        #2;
        chk("rst_stall", {stallF, stallD, stallE, stallM}, 0);
        chk("rst_flush", {flushD, flushE, flushW}, 0);
        chk("rst_fwd", forwardAE, 0);
        tick(); clear(); rst = 0; #2;
        chk("rst_cnt", stallCnt, 0);
        chk("rst_err", memErr, 0);

        // Load-use on rs1
        tick(); resultSrcE = 1; rdE = 5; rs1D = 5; #2;
        chk("lu_stallFD", {stallF, stallD, flushE}, 3'b111);
        chk("lu_noEMW", {stallE, stallM, flushW, flushD}, 0);
        tick(); clear(); #2;
        chk("lu_release", {stallF, stallD, flushE}, 0);
        chk("lu_cnt1", stallCnt, 1);
        // x0 never stalls
        tick(); resultSrcE = 1; rdE = 0; rs1D = 0; #2;
        chk("lu_x0", {stallF, stallD, flushE}, 0);
        // Load-use on rs2
        tick(); clear(); resultSrcE = 1; rdE = 5; rs1D = 6; rs2D = 5; #2;
        chk("lu_rs2", {stallF, stallD, flushE}, 3'b111);
        // Non-writing, non-load instruction in E is harmless
        tick(); clear(); rdE = 5; rs1D = 5; #2;
        chk("nowrite_E", stallF, 0);
        chk("lu_cnt2", stallCnt, 2);

`ifdef FORWARDING_EN
        tick(); clear(); rdM = 3; regWriteM = 1; rdW = 3; regWriteW = 1; rs1E = 3; #2;
        chk("fwd_mem", forwardAE, 2'b10);
        chk("fwd_nostall", stallF, 0);
        regWriteM = 0; #1;
        chk("fwd_wb", forwardAE, 2'b01);
        rs2E = 3; #1;
        chk("fwdB_wb", forwardBE, 2'b01);
        rs1E = 0; rdM = 0; rdW = 0; regWriteM = 1; #1;
        chk("fwd_x0", forwardAE, 2'b00);
`else
        tick(); clear(); rdM = 7; regWriteM = 1; rs2D = 7; #2;
        chk("raw_m_stall", {stallF, stallD, flushE}, 3'b111);
        chk("raw_m_fwdB", forwardBE, 0);
        rs2E = 7; rs1E = 7; #1;
        chk("nofwd_tied", {forwardAE, forwardBE}, 0);
        tick(); clear(); regWriteE = 1; rdE = 4; rs1D = 4; #2;
        chk("raw_e_stall", stallD, 1);
        tick(); clear(); regWriteM = 1; rdM = 0; rs1D = 0; #2;
        chk("raw_x0", stallF, 0);
`endif

        // Branch wins over load-use
        tick(); clear(); pcSrcE = 1; resultSrcE = 1; rdE = 5; rs1D = 5; #2;
        chk("br_flush", {flushD, flushE}, 2'b11);
        chk("br_nostall", {stallF, stallD}, 0);

        // Memory wait of 4 cycles with a branch pending in E
        tick(); clear(); rst = 1;
        tick(); rst = 0; memReqM = 1; pcSrcE = 1;
        for (int i = 0; i < 4; i++) begin
            #2;
            chk("mem_stall", {stallF, stallD, stallE, stallM, flushW}, 5'h1f);
            chk("mem_nobr", {flushD, flushE}, 0);
            tick();
        end
        memAckM = 1; #2;
        chk("mem_release", {stallF, stallD, stallE, stallM, flushW}, 0);
        chk("mem_br_late", {flushD, flushE}, 2'b11);
        tick(); clear(); #2;
        chk("mem_cnt4", stallCnt, 4);
        chk("mem_noerr", memErr, 0);

        // Timeout: ack low for 16 cycles
        tick(); rst = 1;
        tick(); rst = 0; memReqM = 1;
        for (int i = 0; i < 16; i++) begin
            #2;
            if (i == 15) chk("to_err_early", memErr, 0);
            tick();
        end
        memAckM = 1; #2;
        chk("to_err_edge16", memErr, 0);
        tick(); clear(); #2;
        chk("to_err_set", memErr, 1);
        chk("to_cnt16", stallCnt, 16);
        tick(); tick(); #2;
        chk("to_err_hold", memErr, 1);
        tick(); rst = 1;
        tick(); rst = 0; #2;
        chk("to_err_clr", memErr, 0);
        chk("to_cnt_clr", stallCnt, 0);

        // Standalone forward_sel
        tif.rs = 9; tif.rd_m = 9; tif.rd_w = 9; tif.reg_write_m = 1; tif.reg_write_w = 1; #1;
        chk("fs_mem", tif.fwd, 2'b10);
        tif.reg_write_m = 0; #1;
        chk("fs_wb", tif.fwd, 2'b01);
        tif.rd_w = 8; #1;
        chk("fs_none", tif.fwd, 2'b00);
        tif.rs = 0; tif.rd_m = 0; tif.rd_w = 0; tif.reg_write_m = 1; #1;
        chk("fs_x0", tif.fwd, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
